// File: rtl/fir_control.sv
// Sequencing controller for the FIR datapath: sample handshake, TAPS-cycle MAC walk,
// output-register load, and synchronous flush/clear. Holds no sample data.
//
//   state | meaning
//   IDLE  | waiting for a sample handshake
//   LOAD  | shift accepted sample into delay line, clear accumulator
//   MAC   | one tap per cycle, coeff_addr_out = tap counter
//   STORE | load output register; may accept the next sample
//   CLEAR | flush: clear accumulator and output register
module fir_control #(
  parameter  int TAPS  = 8,
  localparam int CBITS = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             input_valid_in,
  output logic             input_ready_out,
  input  logic             flush_in,
  output logic             sample_ld_out,
  output logic             acc_clr_out,
  output logic             acc_en_out,
  output logic [CBITS-1:0] coeff_addr_out,
  output logic             oreg_ld_out,
  output logic             oreg_clr_out,
  output logic             busy_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    STORE = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [CBITS-1:0] LAST_TAP = CBITS'(TAPS - 1);

  state_t           state, state_next;
  logic [CBITS-1:0] cnt, cnt_next;
  logic             handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Ready is the only output that is not a pure state decode: flush blocks acceptance.
  assign handshake = input_valid_in && input_ready_out;

  always_comb begin
    state_next      = state;
    cnt_next        = '0;
    input_ready_out = 1'b0;
    sample_ld_out   = 1'b0;
    acc_clr_out     = 1'b0;
    acc_en_out      = 1'b0;
    coeff_addr_out  = '0;
    oreg_ld_out     = 1'b0;
    oreg_clr_out    = 1'b0;
    busy_out        = 1'b1;

    unique case (state)
      IDLE: begin
        input_ready_out = !flush_in;
        busy_out        = 1'b0;
        if (handshake) state_next = LOAD;
      end
      LOAD: begin
        sample_ld_out = 1'b1;
        acc_clr_out   = 1'b1;
        state_next    = MAC;
      end
      MAC: begin
        acc_en_out     = 1'b1;
        coeff_addr_out = cnt;
        if (cnt == LAST_TAP) begin
          state_next = STORE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STORE: begin
        oreg_ld_out     = 1'b1;
        input_ready_out = !flush_in;
        state_next      = handshake ? LOAD : IDLE;
      end
      CLEAR: begin
        oreg_clr_out = 1'b1;
        acc_clr_out  = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Flush overrides handshake and MAC/STORE progress; STORE's load pulse still goes out.
    if (flush_in) begin
      state_next = CLEAR;
      cnt_next   = '0;
    end
  end

endmodule

// File: tb/tb_fir_control.sv
// Bench for fir_control (TAPS=4): vector table, hand-written corner sequences,
// and random valid/flush traffic checked against a job-position reference model.
module tb_fir_control;

  localparam int TAPS = 4;
  localparam int CB   = $clog2(TAPS);
  localparam int W    = 7 + CB;

  logic          clk;
  logic          rst_n;
  logic          input_valid_in;
  logic          input_ready_out;
  logic          flush_in;
  logic          sample_ld_out;
  logic          acc_clr_out;
  logic          acc_en_out;
  logic [CB-1:0] coeff_addr_out;
  logic          oreg_ld_out;
  logic          oreg_clr_out;
  logic          busy_out;

  fir_control #(.TAPS(TAPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_valid_in (input_valid_in),
    .input_ready_out(input_ready_out),
    .flush_in       (flush_in),
    .sample_ld_out  (sample_ld_out),
    .acc_clr_out    (acc_clr_out),
    .acc_en_out     (acc_en_out),
    .coeff_addr_out (coeff_addr_out),
    .oreg_ld_out    (oreg_ld_out),
    .oreg_clr_out   (oreg_clr_out),
    .busy_out       (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic         flush;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [27];

  int vectors = 0;
  int errors  = 0;

  // Reference: pos = -1 idle, 0 = load cycle, 1..TAPS = MAC cycles, TAPS+1 = store cycle.
  int pos = -1;
  bit clr = 1'b0;
  logic [W-1:0] last_got;

  function automatic logic [W-1:0] got_vec();
    return {input_ready_out, sample_ld_out, acc_clr_out, acc_en_out, coeff_addr_out,
            oreg_ld_out, oreg_clr_out, busy_out};
  endfunction

  function automatic logic [W-1:0] model_exp(input logic f);
    bit idle, store, aen;
    logic [CB-1:0] addr;
    idle  = !clr && pos < 0;
    store = (pos == TAPS + 1);
    aen   = (pos >= 1) && (pos <= TAPS);
    addr  = aen ? CB'(pos - 1) : '0;
    return {(idle || store) && !f, pos == 0, (pos == 0) || clr, aen, addr, store, clr, !idle};
  endfunction

  task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, got, exp);
    end
  endtask

  task automatic compare_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, check, cross the rising edge, advance model.
  task automatic step(input logic v, input logic f, input bit use_tab,
                      input logic [W-1:0] tab_exp, input string name);
    logic [W-1:0] e;
    bit hs;
    input_valid_in = v;
    flush_in       = f;
    #1;
    e        = model_exp(f);
    last_got = got_vec();
    compare(name, last_got, use_tab ? tab_exp : e);
    hs = v && e[W-1];
    @(posedge clk);
    if (f) begin
      clr = 1'b1; pos = -1;
    end else if (clr) begin
      clr = 1'b0; pos = -1;
    end else if (hs) begin
      pos = 0;
    end else if (pos >= 0 && pos < TAPS + 1) begin
      pos++;
    end else begin
      pos = -1;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    pos = -1;
    clr = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic [W-1:0] e);
    vec_t r;
    r.valid = v; r.flush = f; r.exp = e;
    return r;
  endfunction

  int load_cyc[$];
  int oreg_cyc[$];
  int hs_cycle;
  int oreg_at;

  initial begin
    tbl[0]  = mk(1, 0, 9'b1000_00_000);
    tbl[1]  = mk(0, 0, 9'b0110_00_001);
    tbl[2]  = mk(0, 0, 9'b0001_00_001);
    tbl[3]  = mk(0, 0, 9'b0001_01_001);
    tbl[4]  = mk(0, 0, 9'b0001_10_001);
    tbl[5]  = mk(0, 0, 9'b0001_11_001);
    tbl[6]  = mk(0, 0, 9'b1000_00_101);
    tbl[7]  = mk(0, 0, 9'b1000_00_000);
    tbl[8]  = mk(1, 0, 9'b1000_00_000);
    tbl[9]  = mk(0, 0, 9'b0110_00_001);
    tbl[10] = mk(0, 0, 9'b0001_00_001);
    tbl[11] = mk(0, 0, 9'b0001_01_001);
    tbl[12] = mk(0, 1, 9'b0001_10_001);
    tbl[13] = mk(0, 0, 9'b0010_00_011);
    tbl[14] = mk(0, 0, 9'b1000_00_000);
    tbl[15] = mk(1, 1, 9'b0000_00_000);
    tbl[16] = mk(1, 0, 9'b0010_00_011);
    tbl[17] = mk(1, 0, 9'b1000_00_000);
    tbl[18] = mk(0, 0, 9'b0110_00_001);
    tbl[19] = mk(0, 0, 9'b0001_00_001);
    tbl[20] = mk(0, 0, 9'b0001_01_001);
    tbl[21] = mk(0, 0, 9'b0001_10_001);
    tbl[22] = mk(0, 0, 9'b0001_11_001);
    tbl[23] = mk(0, 1, 9'b0000_00_101);
    tbl[24] = mk(0, 1, 9'b0010_00_011);
    tbl[25] = mk(0, 0, 9'b0010_00_011);
    tbl[26] = mk(0, 0, 9'b1000_00_000);

    // Reset held for two cycles with valid high.
    rst_n = 1'b0; input_valid_in = 1'b1; flush_in = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      compare("reset_outputs", got_vec(), 9'b1000_00_000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, '0, "release_handshake");
    step(0, 0, 1, 9'b0110_00_001, "release_load");
    for (int i = 0; i < TAPS + 1; i++) step(0, 0, 0, '0, "release_drain");

    // Table: single sample, flush in MAC, flush+valid in IDLE, flush in STORE.
    for (int i = 0; i < 27; i++)
      step(tbl[i].valid, tbl[i].flush, 1, tbl[i].exp, $sformatf("table[%0d]", i));

    // Back-to-back with valid held high for three samples.
    for (int c = 0; c < 21; c++) begin
      step(load_cyc.size() < 3, 0, 0, '0, "b2b");
      if (last_got[W-2]) load_cyc.push_back(c);
      if (last_got[2])   oreg_cyc.push_back(c);
    end
    compare_int("b2b_load_count", load_cyc.size(), 3);
    compare_int("b2b_oreg_count", oreg_cyc.size(), 3);
    if (load_cyc.size() == 3) begin
      compare_int("b2b_load0", load_cyc[0], 1);
      compare_int("b2b_load1", load_cyc[1], 1 + TAPS + 2);
      compare_int("b2b_load2", load_cyc[2], 1 + 2 * (TAPS + 2));
    end
    if (oreg_cyc.size() == 3) begin
      compare_int("b2b_oreg_gap1", oreg_cyc[1] - oreg_cyc[0], TAPS + 2);
      compare_int("b2b_oreg_gap2", oreg_cyc[2] - oreg_cyc[1], TAPS + 2);
    end

    // Asynchronous reset between edges in the middle of MAC.
    step(1, 0, 0, '0, "areset_hs");
    step(0, 0, 0, '0, "areset_load");
    step(0, 0, 0, '0, "areset_mac0");
    step(0, 0, 0, '0, "areset_mac1");
    #2;
    input_valid_in = 1'b1;
    rst_n = 1'b0;
    #1;
    compare("areset_immediate", got_vec(), 9'b1000_00_000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    oreg_at = -1;
    for (int c = 0; c < 12; c++) begin
      step(c == 0, 0, 0, '0, "areset_after");
      if (last_got[2] && oreg_at < 0) oreg_at = c;
    end
    compare_int("areset_latency", oreg_at, TAPS + 2);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, 0, '0, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
